mips_dmem_responder: RTL and testbench

//  Data-memory responder for the pipelined MIPS core: the memory end of the CPU's

---
 rtl/mips_dmem_responder.sv | 151 +++++++++++++++
 tb/tb_mips_dmem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// ============================================================================
// Module   : mips_dmem_responder
// Brief    : Data-memory responder for the pipelined MIPS core. Serves one
//            load/store at a time with WAIT_CYCLES wait states, a one-cycle
//            memready pulse and a memerr flag for illegal accesses.
//            Optional byte-lane stores when DMEM_BYTE_WRITE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [3:0]  memben,
`endif
    output logic [31:0] memreaddata,
    output logic        memready,
    output logic        memerr,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [32:0] c_addr_limit = 33'(4 * DEPTH);

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic          r_is_store;
    logic          r_is_both;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    logic [3:0]    w_ben;
    logic          w_req;
    logic          w_do_access;
    logic          w_misalign;
    logic          w_oor;
    logic          w_addr_err;
    logic          w_ben_err;
    logic          w_commit;
    logic [AW-1:0] w_idx;

`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]    r_ben;
    assign w_ben = r_ben;
`else
    assign w_ben = 4'hF;
`endif

    assign w_req       = memread | memwrite;
    assign w_do_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_idx       = r_addr[AW+1:2];

    // Partial stores address individual lanes, so only full-word accesses
    // and loads need word alignment.
    assign w_misalign = (r_addr[1:0] != 2'b00) && (!r_is_store || (w_ben == 4'hF));
    assign w_oor      = ({1'b0, r_addr} >= c_addr_limit);
    assign w_addr_err = w_misalign | w_oor;
    assign w_ben_err  = r_is_store && (w_ben == 4'h0);
    assign w_commit   = reset && w_do_access && r_is_store && !w_addr_err && !w_ben_err;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req) w_state_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_state_next = S_RESP;
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr     <= memaddr;
                        r_wdata    <= memwritedata;
                        r_is_store <= memwrite;
                        r_is_both  <= memread & memwrite;
`ifdef DMEM_BYTE_WRITE_EN
                        r_ben      <= memben;
`endif
                        r_cnt      <= 4'(WAIT_CYCLES);
                    end
                end
                S_WAIT: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_err <= w_addr_err | w_ben_err | r_is_both;
                        if (w_addr_err) begin
                            r_rdata <= 32'd0;
                        end else if (!r_is_store) begin
                            r_rdata <= r_mem[w_idx];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_ben[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    assign memready    = (r_state == S_RESP);
    assign memerr      = r_err & memready;
    assign memreaddata = r_rdata;
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mips_dmem_responder.sv
// ============================================================================
// Module   : tb_mips_dmem_responder
// Brief    : Directed, table-driven self-checking bench for mips_dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_dmem_responder;

    localparam int W     = 2;
    localparam int LIMIT = 40;

    typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_BOTH = 2'd2} op_t;

    typedef struct {
        op_t         op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  ben;
        logic        exp_err;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] memaddr;
    logic [31:0] memwritedata;
    logic [3:0]  memben_v;
    logic [31:0] memreaddata;
    logic        memready;
    logic        memerr;
    logic        busy;

    int n_vec;
    int n_err;
    vec_t vecs[$];

    mips_dmem_responder #(
        .DEPTH       (256),
        .WAIT_CYCLES (W),
        .AW          (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memread      (memread),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
`ifdef DMEM_BYTE_WRITE_EN
        .memben       (memben_v),
`endif
        .memreaddata  (memreaddata),
        .memready     (memready),
        .memerr       (memerr),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Returns the number of edges after the accept edge until memready is seen (0 = timeout).
    task automatic wait_ready(output int lat);
        lat = 0;
        for (int k = 1; k <= LIMIT; k++) begin
            @(posedge clk);
            #1;
            if (memready) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic add(input op_t op, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic e, input logic c, input logic [31:0] x);
        vec_t v;
        v.op = op; v.addr = a; v.wdata = d; v.ben = be;
        v.exp_err = e; v.chk_data = c; v.exp_data = x;
        vecs.push_back(v);
    endtask

    initial begin
        int   lat;
        logic seen;

        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        memaddr = 32'd0;
        memwritedata = 32'd0;
        memben_v = 4'hF;

        add(OP_WR,   32'h0000_0000, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'h0);
        add(OP_WR,   32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);
        add(OP_RD,   32'h0000_0013, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0);
        add(OP_RD,   32'h0000_0010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);
        add(OP_WR,   32'h0000_0400, 32'h0000_0001, 4'hF, 1'b1, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0000, 32'h0,         4'hF, 1'b0, 1'b1, 32'h1234_5678);
        add(OP_WR,   32'h0000_03FC, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_03FC, 32'h0,         4'hF, 1'b0, 1'b1, 32'hCAFE_F00D);
        add(OP_RD,   32'h0000_0400, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0);
        add(OP_WR,   32'h0000_0012, 32'h0000_0055, 4'hF, 1'b1, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0010, 32'h0,         4'hF, 1'b0, 1'b1, 32'hDEAD_BEEF);
        add(OP_BOTH, 32'h0000_0014, 32'hA5A5_A5A5, 4'hF, 1'b1, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0014, 32'h0,         4'hF, 1'b0, 1'b1, 32'hA5A5_A5A5);
        add(OP_WR,   32'h0000_0018, 32'h0000_0077, 4'hF, 1'b0, 1'b1, 32'hA5A5_A5A5);
        add(OP_RD,   32'h0000_0018, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0000_0077);
        add(OP_WR,   32'h0000_0010, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0010, 32'h0,         4'hF, 1'b0, 1'b1, 32'h0BAD_F00D);
        add(OP_RD,   32'h1000_0010, 32'h0,         4'hF, 1'b1, 1'b1, 32'h0);
`ifdef DMEM_BYTE_WRITE_EN
        add(OP_WR,   32'h0000_0020, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0);
        add(OP_WR,   32'h0000_0020, 32'h0000_AB00, 4'h2, 1'b0, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h1122_AB44);
        add(OP_WR,   32'h0000_0021, 32'h00CC_0000, 4'h4, 1'b0, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11CC_AB44);
        add(OP_WR,   32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11CC_AB44);
        add(OP_WR,   32'h0000_0022, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, 32'h0);
        add(OP_RD,   32'h0000_0020, 32'h0,         4'hF, 1'b0, 1'b1, 32'h11CC_AB44);
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_memready",    32'(memready),  32'd0);
        check("rst_memerr",      32'(memerr),    32'd0);
        check("rst_memreaddata", memreaddata,    32'd0);
        check("rst_busy",        32'(busy),      32'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            memread      = (vecs[i].op != OP_WR);
            memwrite     = (vecs[i].op != OP_RD);
            memaddr      = vecs[i].addr;
            memwritedata = vecs[i].wdata;
            memben_v     = vecs[i].ben;
            @(posedge clk);
            #1;
            memread  = 1'b0;
            memwrite = 1'b0;
            check($sformatf("v%0d_busy", i), 32'(busy), 32'd1);
            wait_ready(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(W + 1));
            check($sformatf("v%0d_memerr", i), 32'(memerr), 32'(vecs[i].exp_err));
            if (vecs[i].chk_data)
                check($sformatf("v%0d_rdata", i), memreaddata, vecs[i].exp_data);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_pulse_end", i), {30'd0, memready, busy}, 32'd0);
        end

        // Held request: inputs ignored while busy, one-cycle bubble before re-accept
        @(negedge clk);
        memread = 1'b1;
        memaddr = 32'h0000_0010;
        @(posedge clk);
        #1;
        memaddr = 32'h0000_0014;
        wait_ready(lat);
        check("hold_latency", 32'(lat), 32'(W + 1));
        check("hold_rdata", memreaddata, 32'h0BAD_F00D);
        @(posedge clk);
        #1;
        check("bubble_idle", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("bubble_accept", 32'(busy), 32'd1);
        memread = 1'b0;
        wait_ready(lat);
        check("bubble_latency", 32'(lat), 32'(W + 1));
        check("bubble_rdata", memreaddata, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;

        // Reset during WAIT aborts the store
        @(negedge clk);
        memwrite     = 1'b1;
        memaddr      = 32'h0000_0010;
        memwritedata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        memwrite = 1'b0;
        check("abort_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_idle", {30'd0, memready, busy}, 32'd0);
        check("abort_rdata_clr", memreaddata, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (memready) seen = 1'b1;
        end
        check("abort_no_ready", 32'(seen), 32'd0);
        @(negedge clk);
        memread = 1'b1;
        memaddr = 32'h0000_0010;
        @(posedge clk);
        #1;
        memread = 1'b0;
        wait_ready(lat);
        check("abort_latency", 32'(lat), 32'(W + 1));
        check("abort_old_data", memreaddata, 32'h0BAD_F00D);
        check("abort_memerr", 32'(memerr), 32'd0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
